lvdc_pio_master: RTL

//  CPU-side PIO bus sequencer. Upstream of the I/O board, it turns single-cycle

---
 rtl/lvdc_pio_master.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/lvdc_pio_master.sv
// PIO bus sequencer: turns single-cycle core requests into timed
// setup/strobe/hold cycles on DB, I, nIOR and nIOW.
module lvdc_pio_master #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2,
    parameter int TURN_CYC   = 1
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        req,
    input  logic        we,
    input  logic [12:0] addr,
    input  logic [25:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [25:0] rdata,
    output logic [12:0] I,
    output logic [25:0] db_out,
    output logic        db_oe,
    input  logic [25:0] db_in,
    output logic        nIOR,
    output logic        nIOW
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_TURN   = 3'd4;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
    localparam logic [3:0] TURN_LD   = 4'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
    localparam bit         HAS_TURN  = (TURN_CYC > 0);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [25:0] rdata_q, rdata_d;
    logic [12:0] i_q, i_d;
    logic [25:0] db_out_q, db_out_d;
    logic        db_oe_q, db_oe_d;
    logic        nior_q, nior_d;
    logic        niow_q, niow_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rdata_d  = rdata_q;
        i_d      = i_q;
        db_out_d = db_out_q;
        db_oe_d  = db_oe_q;
        nior_d   = nior_q;
        niow_d   = niow_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    i_d     = addr;
                    busy_d  = 1'b1;
                    cnt_d   = SETUP_LD;
                    state_d = S_SETUP;
                    if (we) begin
                        db_out_d = wdata;
                        db_oe_d  = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == 4'd0) begin
                    niow_d  = ~we_q;
                    nior_d  = we_q;
                    cnt_d   = STROBE_LD;
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q == 4'd0) begin
                    nior_d  = 1'b1;
                    niow_d  = 1'b1;
                    cnt_d   = HOLD_LD;
                    state_d = S_HOLD;
                    if (!we_q) begin
                        rdata_d = db_in;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == 4'd0) begin
                    db_oe_d = 1'b0;
                    done_d  = 1'b1;
                    // reads leave a bus-idle gap so a slow peripheral can release DB
                    if (we_q || !HAS_TURN) begin
                        busy_d  = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = TURN_LD;
                        state_d = S_TURN;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_TURN: begin
                if (cnt_q == 4'd0) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
                busy_d  = 1'b0;
                db_oe_d = 1'b0;
                nior_d  = 1'b1;
                niow_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= 26'd0;
            i_q      <= 13'd0;
            db_out_q <= 26'd0;
            db_oe_q  <= 1'b0;
            nior_q   <= 1'b1;
            niow_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            i_q      <= i_d;
            db_out_q <= db_out_d;
            db_oe_q  <= db_oe_d;
            nior_q   <= nior_d;
            niow_q   <= niow_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign rdata  = rdata_q;
    assign I      = i_q;
    assign db_out = db_out_q;
    assign db_oe  = db_oe_q;
    assign nIOR   = nior_q;
    assign nIOW   = niow_q;

endmodule
